// File: rtl/lvds_rx_word_align_7_1.sv
// ---------------------------------------------------------------------------
// lvds_rx_word_align_7_1
// Word aligner for the receive side of the 7:1 LVDS link, in the pixel-clock
// domain after the per-lane 1:7 deserializers. The block searches for the
// 7-bit phase at which the clock lane reads CLK_PATTERN and then applies
// that phase to every data lane.
//
// Ports
//   I_clk_1x    in   1        pixel clock, rising edge
//   I_rst       in   1        synchronous reset, active-high
//   I_clk_word  in   7        deserialized clock-lane word
//   I_data      in   7*LANES  deserialized data lanes, lane n = [7n+6:7n]
//   O_data      out  7*LANES  aligned data words, same packing
//   O_valid     out  1        O_data is aligned and the aligner is locked
//   O_locked    out  1        aligner is in the LOCKED state
//   O_offset    out  3        current bit shift, 0..6
//   O_lost_cnt  out  8        saturating count of LOCKED->SEARCH transitions
// ---------------------------------------------------------------------------
module lvds_rx_word_align_7_1 #(
    parameter int unsigned LANES       = 4,
    parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
    parameter int unsigned SETTLE      = 3,
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned ERR_THRESH  = 4
) (
    input  logic                 I_clk_1x,
    input  logic                 I_rst,
    input  logic [6:0]           I_clk_word,
    input  logic [7*LANES-1:0]   I_data,
    output logic [7*LANES-1:0]   O_data,
    output logic                 O_valid,
    output logic                 O_locked,
    output logic [2:0]           O_offset,
    output logic [7:0]           O_lost_cnt
);

    localparam int unsigned WORD_W = 7;
    localparam int unsigned DATA_W = WORD_W * LANES;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);
    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_CNT);
    localparam logic [3:0] ERR_TARGET  = 4'(ERR_THRESH);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          offset_q, offset_d;
    logic [3:0]          settle_q, settle_d;
    logic [7:0]          match_cnt_q, match_cnt_d;
    logic [3:0]          err_cnt_q, err_cnt_d;
    logic [7:0]          lost_q, lost_d;

    logic [WORD_W-1:0]   clk_cur_q, clk_prev_q;
    logic [DATA_W-1:0]   data_cur_q, data_prev_q;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;

    logic [WORD_W-1:0]   clk_win_c;
    logic                match_c;
    logic [2:0]          offset_next_c;

    // 7-bit window of {prev,cur} starting k bits up from the LSB; k=0 is cur.
    function automatic logic [WORD_W-1:0] window(input logic [WORD_W-1:0] prev,
                                                  input logic [WORD_W-1:0] cur,
                                                  input logic [2:0]        k);
        logic [2*WORD_W-1:0] cat;
        cat = {prev, cur};
        return 7'(cat >> k);
    endfunction

    assign clk_win_c     = window(clk_prev_q, clk_cur_q, offset_q);
    assign match_c       = (clk_win_c == CLK_PATTERN);
    assign offset_next_c = (offset_q == 3'd6) ? 3'd0 : offset_q + 3'd1;

    // Input stage and output register.
    always_ff @(posedge I_clk_1x) begin
        if (I_rst) begin
            clk_cur_q   <= '0;
            clk_prev_q  <= '0;
            data_cur_q  <= '0;
            data_prev_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            clk_cur_q   <= I_clk_word;
            clk_prev_q  <= clk_cur_q;
            data_cur_q  <= I_data;
            data_prev_q <= data_cur_q;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    // State register and alignment counters.
    always_ff @(posedge I_clk_1x) begin
        if (I_rst) begin
            state_q     <= ST_SEARCH;
            offset_q    <= 3'd0;
            settle_q    <= SETTLE_INIT;
            match_cnt_q <= 8'd0;
            err_cnt_q   <= 4'd0;
            lost_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            settle_q    <= settle_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
            lost_q      <= lost_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        settle_d    = settle_q;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;
        lost_d      = lost_q;
        unique case (state_q)
            ST_SEARCH: begin
                // No compare until the window has been stable for SETTLE cycles.
                if (settle_q != 4'd0) begin
                    settle_d = settle_q - 4'd1;
                end else if (match_c) begin
                    match_cnt_d = 8'd1;
                    if (LOCK_TARGET == 8'd1) begin
                        state_d   = ST_LOCKED;
                        err_cnt_d = 4'd0;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end else begin
                    offset_d = offset_next_c;
                    settle_d = SETTLE_INIT;
                end
            end
            ST_VERIFY: begin
                if (match_c) begin
                    match_cnt_d = match_cnt_q + 8'd1;
                    if (match_cnt_q + 8'd1 == LOCK_TARGET) begin
                        state_d   = ST_LOCKED;
                        err_cnt_d = 4'd0;
                    end
                end else begin
                    state_d     = ST_SEARCH;
                    offset_d    = offset_next_c;
                    settle_d    = SETTLE_INIT;
                    match_cnt_d = 8'd0;
                end
            end
            ST_LOCKED: begin
                if (match_c) begin
                    err_cnt_d = 4'd0;
                end else if (err_cnt_q + 4'd1 == ERR_TARGET) begin
                    state_d     = ST_SEARCH;
                    offset_d    = offset_next_c;
                    settle_d    = SETTLE_INIT;
                    match_cnt_d = 8'd0;
                    err_cnt_d   = 4'd0;
                    lost_d      = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
                end else begin
                    err_cnt_d = err_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // Output logic: shift every data lane by the current offset.
    always_comb begin
        data_d = '0;
        for (int n = 0; n < LANES; n++) begin
            data_d[WORD_W*n +: WORD_W] = window(data_prev_q[WORD_W*n +: WORD_W],
                                                data_cur_q[WORD_W*n +: WORD_W],
                                                offset_q);
        end
        valid_d = (state_q == ST_LOCKED);
    end

    assign O_data     = data_q;
    assign O_valid    = valid_q;
    assign O_locked   = (state_q == ST_LOCKED);
    assign O_offset   = offset_q;
    assign O_lost_cnt = lost_q;

endmodule

// File: tb/tb_lvds_rx_word_align_7_1.sv
// ---------------------------------------------------------------------------
// tb_lvds_rx_word_align_7_1
// Directed bench for the 7:1 word aligner. Each driven cycle pushes the
// expected aligned data word into a scoreboard; a monitor pops and compares
// whenever O_valid is high. Lock, offset and loss counters are checked
// directly at hand-computed points.
// ---------------------------------------------------------------------------
module tb_lvds_rx_word_align_7_1;

    localparam int unsigned LANES      = 4;
    localparam logic [6:0]  PAT        = 7'b1100011;
    localparam int unsigned SETTLE     = 3;
    localparam int unsigned LOCK_CNT   = 16;
    localparam int unsigned ERR_THRESH = 4;
    localparam int unsigned DATA_W     = 7 * LANES;
    localparam int unsigned LOCK_BOUND = 7 * (SETTLE + 1) + LOCK_CNT + 2;

    logic              clk = 1'b0;
    logic              I_rst = 1'b1;
    logic [6:0]        I_clk_word = '0;
    logic [DATA_W-1:0] I_data = '0;
    logic [DATA_W-1:0] O_data;
    logic              O_valid;
    logic              O_locked;
    logic [2:0]        O_offset;
    logic [7:0]        O_lost_cnt;

    lvds_rx_word_align_7_1 #(
        .LANES      (LANES),
        .CLK_PATTERN(PAT),
        .SETTLE     (SETTLE),
        .LOCK_CNT   (LOCK_CNT),
        .ERR_THRESH (ERR_THRESH)
    ) dut (
        .I_clk_1x  (clk),
        .I_rst     (I_rst),
        .I_clk_word(I_clk_word),
        .I_data    (I_data),
        .O_data    (O_data),
        .O_valid   (O_valid),
        .O_locked  (O_locked),
        .O_offset  (O_offset),
        .O_lost_cnt(O_lost_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb[$];

    // Current stimulus and the aligned words it should produce.
    logic              rst_w = 1'b1;
    logic [6:0]        clk_w = '0;
    logic [6:0]        good_w = '0;
    logic [6:0]        bad_w = '0;
    logic [DATA_W-1:0] data_w = '0;
    logic [DATA_W-1:0] exp_w = '0;

    // Serial bit slip of k: the deserializer delivers the word rotated left by k.
    function automatic logic [6:0] rotl7(input logic [6:0] w, input int k);
        logic [13:0] t;
        t = {7'd0, w} << k;
        return t[6:0] | t[13:7];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Build a stream slipped by k. The corrupt word only disturbs the bits that
    // the current word contributes to the window, so it costs exactly one compare.
    task automatic set_stream(input int k);
        logic [6:0] lanes [LANES];
        logic [6:0] mask;
        lanes[0] = 7'h2A;
        lanes[1] = 7'h55;
        lanes[2] = 7'h0F;
        lanes[3] = 7'h71;
        for (int n = 0; n < LANES; n++) begin
            data_w[7*n +: 7] = rotl7(lanes[n], k);
            exp_w[7*n +: 7]  = lanes[n];
        end
        good_w = rotl7(PAT, k);
        mask   = 7'((1 << k) - 1);
        bad_w  = good_w & mask;
        clk_w  = good_w;
    endtask

    // Drive one cycle of stimulus; its aligned output is due two edges later.
    task automatic step();
        exp_t e;
        @(negedge clk);
        I_rst      = rst_w;
        I_clk_word = clk_w;
        I_data     = data_w;
        e.due      = cyc + 2;
        e.data     = exp_w;
        sb.push_back(e);
    endtask

    task automatic pulse_reset();
        rst_w = 1'b1;
        step();
        rst_w = 1'b0;
        step();
    endtask

    task automatic wait_lock(input string name, input logic [2:0] req_off, output bit wrapped);
        int         n;
        logic [2:0] last;
        wrapped = 1'b0;
        last    = O_offset;
        n       = 0;
        while (!O_locked && n < int'(LOCK_BOUND)) begin
            step();
            n++;
            if (last == 3'd6 && O_offset == 3'd0) wrapped = 1'b1;
            last = O_offset;
        end
        chk({name, "_locked"}, 32'(O_locked), 32'd1);
        chk({name, "_offset"}, 32'(O_offset), 32'(req_off));
    endtask

    task automatic lose_lock();
        clk_w = bad_w;
        repeat (ERR_THRESH) step();
        clk_w = good_w;
        step();
        step();
    endtask

    // Scoreboard monitor.
    initial begin : monitor
        forever begin
            exp_t e;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
            if (O_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    errors++;
                    $display("FAIL sb_orphan valid with no expected word at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    if (O_data !== e.data) begin
                        errors++;
                        $display("FAIL sb_data cycle %0d actual=%0h required=%0h", cyc, O_data, e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit wrapped;
        bit stay;
        bit never;

        // Test 1: slip 3, lock from reset, lane 0 reads 2A.
        set_stream(3);
        pulse_reset();
        chk("rst_locked", 32'(O_locked), 32'd0);
        chk("rst_valid", 32'(O_valid), 32'd0);
        chk("rst_offset", 32'(O_offset), 32'd0);
        chk("rst_lost", 32'(O_lost_cnt), 32'd0);
        chk("rst_data", 32'(O_data), 32'd0);
        wait_lock("t1", 3'd3, wrapped);
        repeat (3) step();
        chk("t1_lane0", 32'(O_data[6:0]), 32'h2A);
        chk("t1_valid", 32'(O_valid), 32'd1);
        repeat (20) step();

        // Test 2: one bad clock word at VERIFY match 10 (compare at edge R+25).
        pulse_reset();
        repeat (22) step();
        chk("t2_not_locked", 32'(O_locked), 32'd0);
        clk_w = bad_w;
        step();
        clk_w = good_w;
        step();
        step();
        chk("t2_offset_adv", 32'(O_offset), 32'd4);
        chk("t2_unlocked", 32'(O_locked), 32'd0);
        wait_lock("t2", 3'd3, wrapped);
        chk("t2_wrap", 32'(wrapped), 32'd1);
        chk("t2_lost", 32'(O_lost_cnt), 32'd0);
        repeat (10) step();

        // Test 3: two bursts of 3 bad words keep lock; 4 bad words drop it.
        for (int b = 0; b < 2; b++) begin
            stay  = 1'b1;
            clk_w = bad_w;
            repeat (ERR_THRESH - 1) begin
                step();
                stay &= O_locked;
            end
            clk_w = good_w;
            repeat (4) begin
                step();
                stay &= O_locked;
            end
            chk("t3_stay_locked", 32'(stay), 32'd1);
        end
        clk_w = bad_w;
        repeat (ERR_THRESH) step();
        clk_w = good_w;
        step();
        chk("t3_before_4th", 32'(O_locked), 32'd1);
        step();
        chk("t3_after_4th", 32'(O_locked), 32'd0);
        chk("t3_lost", 32'(O_lost_cnt), 32'd1);
        chk("t3_offset", 32'(O_offset), 32'd4);
        wait_lock("t3", 3'd3, wrapped);

        // Test 4: dead clock lane; offset walks 0..6,0 every SETTLE+1 cycles.
        good_w = 7'h00;
        clk_w  = 7'h00;
        pulse_reset();
        chk("t4_rst_lost", 32'(O_lost_cnt), 32'd0);
        never = 1'b1;
        for (int j = 0; j < 60; j++) begin
            chk("t4_offset", 32'(O_offset), 32'((j / (SETTLE + 1)) % 7));
            never &= ~O_locked;
            step();
        end
        chk("t4_never_locked", 32'(never), 32'd1);

        // Test 5: slip 5, induce one loss, then reset while locked.
        set_stream(5);
        pulse_reset();
        wait_lock("t5", 3'd5, wrapped);
        repeat (20) step();
        lose_lock();
        chk("t5_lost", 32'(O_lost_cnt), 32'd1);
        wait_lock("t5_relock", 3'd5, wrapped);
        repeat (5) step();
        pulse_reset();
        chk("t5_rst_locked", 32'(O_locked), 32'd0);
        chk("t5_rst_valid", 32'(O_valid), 32'd0);
        chk("t5_rst_offset", 32'(O_offset), 32'd0);
        chk("t5_rst_lost", 32'(O_lost_cnt), 32'd0);
        chk("t5_rst_data", 32'(O_data), 32'd0);
        wait_lock("t5_after_rst", 3'd5, wrapped);

        // Test 6: 257 losses; the counter saturates at 255.
        for (int i = 0; i < 257; i++) begin
            lose_lock();
            chk("t6_lost", 32'(O_lost_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            wait_lock("t6", 3'd5, wrapped);
        end
        chk("t6_saturated", 32'(O_lost_cnt), 32'd255);

        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
